// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - digit-serial add/subtract with valid/ready handshakes
module serial_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_digit_adder: WIDTH must be >= 1 and a multiple of DIGIT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  // One digit of the addition: DIGIT+1 bits so the carry out falls in the top bit.
  logic [DIGIT:0]   dsum;
  logic             msb_cin;

  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // Carry into the digit's top bit, recovered from that bit's sum = a ^ b ^ cin.
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];

  // Next-state and datapath updates; subtract is a + ~b + ~borrow_in.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = c_in ^ sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
        carry_d = dsum[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          c_out_d = dsum[DIGIT];
          ovf_d   = msb_cin ^ dsum[DIGIT];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// tb/tb_serial_digit_adder.sv - directed and sweep checks for serial_digit_adder
module tb_serial_digit_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit, 2-bit digit instance
  logic       iv8, ir8, ov8, or8, c8, sb8, co8, of8;
  logic [7:0] a8, b8, s8;

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .c_in(c8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .s(s8),
    .c_out(co8), .ovf(of8)
  );

  // 16-bit instances with DIGIT = 1, 4, 16
  logic [15:0] a16, b16;
  logic        c16, sb16;
  logic        iv16 [3];
  logic        or16 [3];
  logic        ir16 [3];
  logic        ov16 [3];
  logic        co16 [3];
  logic        of16 [3];
  logic [15:0] s16  [3];

  for (genvar k = 0; k < 3; k++) begin : g16
    serial_digit_adder #(.WIDTH(16), .DIGIT(k == 0 ? 1 : (k == 1 ? 4 : 16))) u_dut (
      .clk(clk), .reset(rst), .in_valid(iv16[k]), .in_ready(ir16[k]), .a(a16), .b(b16),
      .c_in(c16), .sub(sb16), .out_valid(ov16[k]), .out_ready(or16[k]), .s(s16[k]),
      .c_out(co16[k]), .ovf(of16[k])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid on the 8-bit DUT from the negedge after acceptance; returns edges taken.
  task automatic wait8(input string tag, output int n);
    n = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
      if (!ov8) chk({tag, " in_ready busy"}, 32'(ir8), 32'd0);
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic sb,
                     input logic [7:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(ir8), 32'd1);
    a8 = a; b8 = b; c8 = c; sb8 = sb; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    a8 = 8'hxx; b8 = 8'hxx;
    chk({tag, " in_ready t+1"}, 32'(ir8), 32'd0);
    wait8(tag, n);
    chk({tag, " latency"}, 32'(n), 32'd4);
    chk({tag, " s"}, 32'(s8), 32'(es));
    chk({tag, " c_out"}, 32'(co8), 32'(ec));
    chk({tag, " ovf"}, 32'(of8), 32'(eo));
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk({tag, " out_valid drop"}, 32'(ov8), 32'd0);
    chk({tag, " in_ready back"}, 32'(ir8), 32'd1);
  endtask

  task automatic op16(input int k, input int n_exp);
    logic [15:0] bb;
    logic [16:0] sum;
    logic [15:0] es;
    logic        eo;
    int          n;
    @(negedge clk);
    a16 = 16'($urandom); b16 = 16'($urandom);
    c16 = 1'($urandom); sb16 = 1'($urandom);
    bb  = sb16 ? ~b16 : b16;
    sum = {1'b0, a16} + {1'b0, bb} + 17'(c16 ^ sb16);
    es  = sum[15:0];
    eo  = (a16[15] == bb[15]) && (es[15] != a16[15]);
    chk("sweep in_ready", 32'(ir16[k]), 32'd1);
    iv16[k] = 1'b1;
    @(negedge clk);
    iv16[k] = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    c16 = 1'($urandom); sb16 = 1'($urandom);
    n = 0;
    while (!ov16[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sweep latency", 32'(n), 32'(n_exp));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("sweep s", 32'(s16[k]), 32'(es));
    chk("sweep c_out", 32'(co16[k]), 32'(sum[16]));
    chk("sweep ovf", 32'(of16[k]), 32'(eo));
    or16[k] = 1'b1;
    @(negedge clk);
    or16[k] = 1'b0;
    chk("sweep out_valid drop", 32'(ov16[k]), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sb8 = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0; sb16 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv16[k] = 1'b0;
      or16[k] = 1'b0;
    end

    // Reset state
    #12;
    chk("reset in_ready", 32'(ir8), 32'd1);
    chk("reset out_valid", 32'(ov8), 32'd0);
    chk("reset s", 32'(s8), 32'd0);
    chk("reset c_out", 32'(co8), 32'd0);
    chk("reset ovf", 32'(of8), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Add with signed overflow, add wrap, carry-in overflow
    op8("add5A3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op8("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add7F00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

    // Subtract: borrow, signed overflow, borrow-in
    op8("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    op8("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub0505b", 8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

    // Backpressure: result held while new operands wait on in_valid
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; sb8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02;
    wait8("bp", n);
    chk("bp latency", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp s stable", 32'(s8), 32'h46);
      chk("bp c_out stable", 32'(co8), 32'd0);
      chk("bp ovf stable", 32'(of8), 32'd0);
      chk("bp out_valid held", 32'(ov8), 32'd1);
      chk("bp in_ready low", 32'(ir8), 32'd0);
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("bp idle out_valid", 32'(ov8), 32'd0);
    chk("bp idle in_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    iv8 = 1'b0;
    chk("bp accept next", 32'(ir8), 32'd0);
    wait8("bp2", n);
    chk("bp2 latency", 32'(n), 32'd4);
    chk("bp2 s", 32'(s8), 32'h03);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;

    // Reset in the middle of an operation, two digits in
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; c8 = 1'b0; sb8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst mid in_ready", 32'(ir8), 32'd1);
    chk("rst mid out_valid", 32'(ov8), 32'd0);
    chk("rst mid s", 32'(s8), 32'd0);
    chk("rst mid c_out", 32'(co8), 32'd0);
    chk("rst mid ovf", 32'(of8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst no stale out_valid", 32'(ov8), 32'd0);
    end
    op8("add0101", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    // Configuration sweep against a whole-word model
    for (int i = 0; i < 1000; i++) op16(0, 16);
    for (int i = 0; i < 1000; i++) op16(1, 4);
    for (int i = 0; i < 1000; i++) op16(2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
